// File: rtl/pac_sprite_sched.sv
// rtl/pac_sprite_sched.sv - Pac-Man sprite ROM scheduler with mouth animation and round-robin fetch arbiter
module pac_sprite_sched #(
  parameter int ANIM_FRAMES = 8,
  parameter int CNT_W       = 8
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_tick,
  input  logic [1:0]  dir,
  input  logic        moving,
  input  logic        pac_req,
  input  logic [3:0]  pac_row,
  output logic        pac_ack,
  input  logic        ghost_req,
  input  logic [3:0]  ghost_row,
  output logic        ghost_ack,
  output logic [15:0] rd_data,
  output logic [6:0]  rom_addr,
  input  logic [15:0] rom_data,
  output logic        mouth_open
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic GNT_PAC   = 1'b0;
  localparam logic GNT_GHOST = 1'b1;

  localparam logic [2:0] SPR_LEFT   = 3'd0;
  localparam logic [2:0] SPR_CLOSED = 3'd1;
  localparam logic [2:0] SPR_GHOST  = 3'd2;
  localparam logic [2:0] SPR_UP     = 3'd3;
  localparam logic [2:0] SPR_DOWN   = 3'd4;
  localparam logic [2:0] SPR_RIGHT  = 3'd5;

  localparam logic [CNT_W-1:0] ANIM_LAST = CNT_W'(ANIM_FRAMES - 1);

  state_t           r_state;
  logic             r_last_grant;
  logic [CNT_W-1:0] r_anim_cnt;
  logic             r_mouth_open;
  logic [6:0]       r_rom_addr;
  logic [15:0]      r_rd_data;
  logic             r_pac_ack;
  logic             r_ghost_ack;

  logic [2:0]       w_pac_sprite;
  logic             w_pac_win;

  // Pac-Man sprite: closed mouth overrides heading
  always_comb begin
    w_pac_sprite = SPR_LEFT;
    if (!r_mouth_open) begin
      w_pac_sprite = SPR_CLOSED;
    end else begin
      case (dir)
        2'b00:   w_pac_sprite = SPR_LEFT;
        2'b01:   w_pac_sprite = SPR_UP;
        2'b10:   w_pac_sprite = SPR_DOWN;
        default: w_pac_sprite = SPR_RIGHT;
      endcase
    end
  end

  // Pac-Man wins when alone, or on a tie when the ghost was served last
  assign w_pac_win = pac_req && (!ghost_req || (r_last_grant == GNT_GHOST));

  // Mouth animation; standing still forces an open mouth and restarts the phase
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_anim_cnt   <= '0;
      r_mouth_open <= 1'b1;
    end else if (!moving) begin
      r_anim_cnt   <= '0;
      r_mouth_open <= 1'b1;
    end else if (frame_tick) begin
      if (r_anim_cnt == ANIM_LAST) begin
        r_anim_cnt   <= '0;
        r_mouth_open <= ~r_mouth_open;
      end else begin
        r_anim_cnt <= r_anim_cnt + 1'b1;
      end
    end
  end

  // Fetch sequencer: grant and latch address, capture ROM row, then pulse the winner's ack
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state      <= IDLE;
      r_last_grant <= GNT_GHOST;
      r_rom_addr   <= '0;
      r_rd_data    <= '0;
      r_pac_ack    <= 1'b0;
      r_ghost_ack  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_pac_ack   <= 1'b0;
          r_ghost_ack <= 1'b0;
          if (w_pac_win) begin
            r_rom_addr   <= {w_pac_sprite, pac_row};
            r_last_grant <= GNT_PAC;
            r_state      <= ADDR;
          end else if (ghost_req) begin
            r_rom_addr   <= {SPR_GHOST, ghost_row};
            r_last_grant <= GNT_GHOST;
            r_state      <= ADDR;
          end
        end
        ADDR: begin
          r_rd_data   <= rom_data;
          r_pac_ack   <= (r_last_grant == GNT_PAC);
          r_ghost_ack <= (r_last_grant == GNT_GHOST);
          r_state     <= DATA;
        end
        DATA: begin
          r_pac_ack   <= 1'b0;
          r_ghost_ack <= 1'b0;
          r_state     <= IDLE;
        end
        default: begin
          r_pac_ack   <= 1'b0;
          r_ghost_ack <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign pac_ack    = r_pac_ack;
  assign ghost_ack  = r_ghost_ack;
  assign rd_data    = r_rd_data;
  assign rom_addr   = r_rom_addr;
  assign mouth_open = r_mouth_open;

endmodule

// File: tb/tb_pac_sprite_sched.sv
// tb/tb_pac_sprite_sched.sv - directed self-checking bench for pac_sprite_sched
module tb_pac_sprite_sched;

  logic        Clk;
  logic        Reset_n;
  logic        frame_tick;
  logic [1:0]  dir;
  logic        moving;
  logic        pac_req;
  logic [3:0]  pac_row;
  logic        pac_ack;
  logic        ghost_req;
  logic [3:0]  ghost_row;
  logic        ghost_ack;
  logic [15:0] rd_data;
  logic [6:0]  rom_addr;
  logic [15:0] rom_data;
  logic        mouth_open;

  int n_tests = 0;
  int n_fail  = 0;

  pac_sprite_sched #(.ANIM_FRAMES(8), .CNT_W(8)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .frame_tick (frame_tick),
    .dir        (dir),
    .moving     (moving),
    .pac_req    (pac_req),
    .pac_row    (pac_row),
    .pac_ack    (pac_ack),
    .ghost_req  (ghost_req),
    .ghost_row  (ghost_row),
    .ghost_ack  (ghost_ack),
    .rd_data    (rd_data),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .mouth_open (mouth_open)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // sprite ROM model: known rows from the artwork, a filler pattern elsewhere
  function automatic logic [15:0] rom_fn(input logic [6:0] a);
    case (a)
      7'd83:   rom_fn = 16'b1111111111111100;
      7'd32:   rom_fn = 16'b0000111111110000;
      7'd21:   rom_fn = 16'b0111111111111110;
      7'd63:   rom_fn = 16'b0;
      7'd64:   rom_fn = 16'b0;
      default: rom_fn = {a, 2'b10, a};
    endcase
  endfunction

  assign rom_data = rom_fn(rom_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse_frame;
    frame_tick = 1'b1;
    tick;
    frame_tick = 1'b0;
    tick;
  endtask

  // one fetch from IDLE: grant edge, capture edge, ack cycle, back to IDLE
  task automatic fetch(input string tag, input logic ghost, input logic [3:0] row,
                       input logic [6:0] ea, input logic [15:0] ed);
    if (ghost) begin
      ghost_req = 1'b1;
      ghost_row = row;
    end else begin
      pac_req = 1'b1;
      pac_row = row;
    end
    tick;
    chk({tag, "_addr"}, rom_addr, ea);
    chk({tag, "_ack_in_addr"}, {pac_ack, ghost_ack}, 2'b00);
    tick;
    chk({tag, "_ack"}, {pac_ack, ghost_ack}, ghost ? 2'b01 : 2'b10);
    chk({tag, "_rd_data"}, rd_data, ed);
    pac_req   = 1'b0;
    ghost_req = 1'b0;
    tick;
    chk({tag, "_ack_idle"}, {pac_ack, ghost_ack}, 2'b00);
    chk({tag, "_rd_hold"}, rd_data, ed);
  endtask

  initial begin
    logic [3:0] order;
    int ng;
    logic pac_seen, pac_dn, gh_seen, gh_dn;

    Reset_n    = 1'b0;
    frame_tick = 1'b0;
    dir        = 2'b11;
    moving     = 1'b1;
    pac_req    = 1'b0;
    pac_row    = 4'd0;
    ghost_req  = 1'b0;
    ghost_row  = 4'd0;
    tick;
    tick;
    chk("rst_rom_addr", rom_addr, 7'd0);
    chk("rst_rd_data", rd_data, 16'd0);
    chk("rst_acks", {pac_ack, ghost_ack}, 2'b00);
    chk("rst_mouth", mouth_open, 1'b1);
    Reset_n = 1'b1;
    tick;

    // right-facing open mouth, then ghost alone
    fetch("pac_right", 1'b0, 4'd3, 7'd83, 16'b1111111111111100);
    fetch("ghost0", 1'b1, 4'd0, 7'd32, 16'b0000111111110000);

    // animation: mouth closes on the 8th tick
    for (int i = 0; i < 7; i++) pulse_frame;
    chk("mouth_after7", mouth_open, 1'b1);
    pulse_frame;
    chk("mouth_after8", mouth_open, 1'b0);
    fetch("pac_closed", 1'b0, 4'd5, 7'd21, 16'b0111111111111110);
    moving = 1'b0;
    tick;
    chk("mouth_stop", mouth_open, 1'b1);
    // restarting motion needs a full 8 ticks again: counter was cleared
    moving = 1'b1;
    for (int i = 0; i < 7; i++) pulse_frame;
    chk("mouth_restart7", mouth_open, 1'b1);
    pulse_frame;
    chk("mouth_restart8", mouth_open, 1'b0);
    moving = 1'b0;
    tick;
    moving = 1'b1;

    // remaining headings
    dir = 2'b01;
    fetch("pac_up", 1'b0, 4'd15, 7'd63, 16'b0);
    dir = 2'b10;
    fetch("pac_down", 1'b0, 4'd0, 7'd64, 16'b0);
    dir = 2'b00;
    fetch("pac_left", 1'b0, 4'd7, 7'd7, {7'd7, 2'b10, 7'd7});

    // both requesting from reset: grants must alternate starting with Pac-Man
    Reset_n   = 1'b0;
    dir       = 2'b11;
    pac_row   = 4'd3;
    ghost_row = 4'd0;
    pac_req   = 1'b1;
    ghost_req = 1'b1;
    tick;
    Reset_n  = 1'b1;
    ng       = 0;
    order    = 4'b0000;
    pac_seen = 1'b0;
    pac_dn   = 1'b0;
    gh_seen  = 1'b0;
    gh_dn    = 1'b0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      tick;
      chk("dual_ack", pac_ack & ghost_ack, 1'b0);
      if (pac_dn) begin pac_req = 1'b1; pac_dn = 1'b0; end
      if (pac_seen) begin pac_req = 1'b0; pac_seen = 1'b0; pac_dn = 1'b1; end
      if (gh_dn) begin ghost_req = 1'b1; gh_dn = 1'b0; end
      if (gh_seen) begin ghost_req = 1'b0; gh_seen = 1'b0; gh_dn = 1'b1; end
      if (pac_ack && ng < 4) begin
        order[ng] = 1'b0;
        ng++;
        pac_seen = 1'b1;
      end else if (ghost_ack && ng < 4) begin
        order[ng] = 1'b1;
        ng++;
        gh_seen = 1'b1;
      end
    end
    chk("rr_grant_count", ng, 4);
    chk("rr_order", order, 4'b1010);
    pac_req   = 1'b0;
    ghost_req = 1'b0;
    tick;
    tick;
    tick;
    chk("rr_last_data", rd_data, 16'b0000111111110000);

    // reset in the middle of a closed-mouth pac fetch
    for (int i = 0; i < 8; i++) pulse_frame;
    chk("mouth_pre_rst", mouth_open, 1'b0);
    dir     = 2'b11;
    pac_row = 4'd3;
    pac_req = 1'b1;
    tick;
    chk("midrst_addr", rom_addr, 7'd19);
    Reset_n = 1'b0;
    #1;
    chk("midrst_rd_data", rd_data, 16'd0);
    chk("midrst_rom_addr", rom_addr, 7'd0);
    chk("midrst_mouth", mouth_open, 1'b1);
    chk("midrst_ack", {pac_ack, ghost_ack}, 2'b00);
    tick;
    chk("midrst_no_ack", {pac_ack, ghost_ack}, 2'b00);
    Reset_n = 1'b1;
    fetch("post_rst", 1'b0, 4'd3, 7'd83, 16'b1111111111111100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pac_sprite_sched.md
Name: pac_sprite_sched

Overview:
- Sequences and shares the 96x16 Pac-Man sprite ROM between two draw requesters: the Pac-Man drawer and the ghost drawer.
- The ROM holds 6 sprites of 16 rows each: 0 = left, 1 = closed, 2 = ghost, 3 = up, 4 = down, 5 = right. ROM address is {sprite[2:0], row[3:0]}.
- Runs a mouth-animation FSM, clocked by frame ticks, that selects Pac-Man's sprite.
- Arbitrates row fetches round-robin and returns registered row data with a req/ack handshake.

Parameters:
- ANIM_FRAMES, 8, number of frame_tick pulses per mouth phase; legal range 1..255.
- CNT_W, 8, width of the animation counter.

Ports:
- Clk  in  1  system clock; all logic is rising-edge.
- Reset_n  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-Clk pulse per video frame.
- dir  in  2  Pac-Man heading: 00 left, 01 up, 10 down, 11 right.
- moving  in  1  1 = Pac-Man is in motion, so animate.
- pac_req  in  1  Pac-Man row fetch request; held high until ack.
- pac_row  in  4  row index for the Pac-Man fetch; stable while pac_req is high.
- pac_ack  out  1  one-cycle pulse; rd_data is valid in the same cycle.
- ghost_req  in  1  ghost row fetch request; held high until ack.
- ghost_row  in  4  row index for the ghost fetch; stable while ghost_req is high.
- ghost_ack  out  1  one-cycle pulse; rd_data is valid in the same cycle.
- rd_data  out  16  fetched sprite row; holds its value between fetches.
- rom_addr  out  7  registered address driven to the sprite ROM.
- rom_data  in  16  combinational ROM output for rom_addr.
- mouth_open  out  1  current animation phase.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE, anim_cnt = 0, mouth_open = 1.
  - last_grant = GHOST, so Pac-Man wins the first tie.
  - rom_addr = 0, rd_data = 0, pac_ack = 0, ghost_ack = 0.
- Animation:
  - On frame_tick with moving = 1: if anim_cnt == ANIM_FRAMES-1, set anim_cnt = 0 and toggle mouth_open; else increment anim_cnt.
  - moving = 0 (any cycle): anim_cnt = 0 and mouth_open = 1 on the next edge. moving has priority over frame_tick.
  - ANIM_FRAMES = 1 toggles on every tick.
- Pac-Man sprite select, evaluated at grant:
  - mouth_open = 0 → sprite 1.
  - Otherwise dir maps 00→0, 01→3, 10→4, 11→5.
- Ghost sprite is always 2.
- FSM states: IDLE, ADDR, DATA.
  - IDLE: if any req is high, grant, then load rom_addr = {sprite, row} and record the winner in last_grant; go to ADDR. Otherwise stay.
  - ADDR: rom_data settles; capture rd_data <= rom_data; go to DATA.
  - DATA: assert the winner's ack for exactly this cycle; go to IDLE.
- Latency: 3 cycles from req sampled high in IDLE to the ack cycle. Throughput: one fetch per 3 cycles.
- Arbitration:
  - Only one requester high → grant it.
  - Both high → grant the one that is not last_grant.
- Requester contract:
  - The requester must drop req in the cycle after ack, otherwise a new fetch starts.
  - A req that drops before grant is ignored.
  - Row and sprite are sampled only in the IDLE grant cycle. dir/mouth changes mid-fetch do not affect the fetch in flight.
- Never assert both acks in one cycle. Ack is never asserted outside DATA.
- frame_tick during a fetch is processed normally; animation is independent of the FSM.
- Reset mid-fetch: abort immediately, no ack issued, all outputs return to their reset values.

Test Plan:
- Reset then dir = 11, moving = 1, mouth_open = 1; pac_req with pac_row = 3 → rom_addr = 7'd83 in ADDR. pac_ack 3 cycles after req, with rd_data = 16'b1111111111111100.
- ghost_req with ghost_row = 0 alone → rom_addr = 7'd32, ghost_ack with rd_data = 16'b0000111111110000; pac_ack stays 0.
- ANIM_FRAMES = 8, moving = 1, 8 frame_ticks → mouth_open falls on the 8th tick edge. Then pac_req with row 5 → rom_addr = 7'd21, rd_data = 16'b0111111111111110. Deassert moving → mouth_open = 1 next cycle, anim_cnt = 0.
- pac_req and ghost_req both held high continuously from reset, each dropping for one cycle after its ack and reasserting → grants alternate PAC, GHOST, PAC, GHOST; never two acks in one cycle.
- dir = 01 with row 15 → rom_addr = 7'd63, rd_data = 16'b0. dir = 10 with row 0 → rom_addr = 7'd64, rd_data = 16'b0.
- Assert Reset_n low during ADDR of a pac fetch → no pac_ack, rd_data = 0, mouth_open = 1 asynchronously. After release, pending pac_req is serviced normally.
